// File: rtl/ramb_writer.sv
// ramb_writer: streams a DIM x DIM signed matrix B into a RAM write port.
// Optional build macro RAMB_WRITER_TRANSPOSE_EN stores B column-major.
module ramb_writer #(
   parameter int DATA_W = 8,
   parameter int DIM    = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] count
);

   localparam int NELEM = DIM * DIM;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NELEM - 1);
   localparam logic [ADDR_W-1:0] DIM_A = ADDR_W'(DIM);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              accept;

   // element index to RAM address; column-major when transposing
   function automatic logic [ADDR_W-1:0] map_addr(
      input logic [ADDR_W-1:0] k
   );
`ifdef RAMB_WRITER_TRANSPOSE_EN
      map_addr = (k % DIM_A) * DIM_A + (k / DIM_A);
`else
      map_addr = k;
`endif
   endfunction

   assign in_ready = (state_q == LOAD);
   assign accept   = in_valid & in_ready;

   // next-state, counter and write-port decode
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = LOAD;
               count_d = '0;
            end
         end
         LOAD: begin
            if (accept) begin
               we_d    = 1'b1;
               waddr_d = map_addr(count_q);
               wdata_d = in_data;
               count_d = count_q + ADDR_W'(1);
               if (count_q == LAST) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // all state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign we    = we_q;
   assign waddr = waddr_q;
   assign wdata = wdata_q;
   assign count = count_q;
   assign busy  = (state_q == LOAD);
   assign done  = (state_q == DONE);

endmodule

// File: doc/ramb_writer.md
RAMB_WRITER -- requirements
Module: ramb_writer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the signed element width in bits.
REQ-002 Parameter DIM, default 8, SHALL set the matrix dimension; the matrix holds DIM*DIM elements (64 by default).
REQ-003 Parameter ADDR_W, default 8, SHALL set the RAM address width.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  input  1  SHALL request a new load of matrix B; it is sampled only in IDLE or DONE.
REQ-007 in_valid  input  1  SHALL mark in_data as valid.
REQ-008 in_data  input  DATA_W  SHALL carry one signed element, streamed row-major.
REQ-009 in_ready  output  1  SHALL indicate the block accepts an element this cycle.
REQ-010 we  output  1  SHALL be the RAM B write enable, one cycle per element.
REQ-011 waddr  output  ADDR_W  SHALL be the RAM B write address.
REQ-012 wdata  output  DATA_W  SHALL be the RAM B write data.
REQ-013 busy  output  1  SHALL be high while in LOAD.
REQ-014 done  output  1  SHALL be high while in DONE, until the next start.
REQ-015 count  output  ADDR_W  SHALL give the number of elements accepted in the current load.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD and DONE.
- IDLE to LOAD on start.
- LOAD to DONE on acceptance of element DIM*DIM-1.
- DONE to LOAD on start.
REQ-017 An element SHALL be accepted exactly when in_valid and in_ready are both 1 at a rising edge.
REQ-018 in_ready SHALL equal (state==LOAD), combinationally; it is 0 in IDLE and DONE.
REQ-019 An element accepted at edge N SHALL produce we=1 with waddr and wdata registered at edge N, visible during cycle N+1 (latency 1).
REQ-020 we SHALL be 0 in every cycle that does not follow an acceptance; waddr and wdata SHALL hold their last values when we=0.
REQ-021 Element k (0 to DIM*DIM-1) SHALL be written to waddr=k, zero-extended to ADDR_W, unless REQ-029 applies.
REQ-022 count SHALL increment by 1 per acceptance, clear to 0 on the start edge, and hold at DIM*DIM in DONE.
REQ-023 in_valid=0 in LOAD (a stall) SHALL leave the count, address and FSM unchanged, with no write.
REQ-024 start asserted while in LOAD SHALL be ignored; no restart, and the counters are not disturbed.
REQ-025 start and in_valid asserted in the same cycle in IDLE SHALL accept no element that cycle, because in_ready=0.
REQ-026 The final write (k=DIM*DIM-1) SHALL occur in the first cycle of DONE; done and that we are high together.
REQ-027 wdata SHALL be the bit-exact in_data, with no sign manipulation.

Reset
REQ-028 On rst_n=0, asynchronously:
- state=IDLE
- we=0, waddr=0, wdata=0
- count=0, busy=0, done=0, in_ready=0
A reset asserted mid-LOAD SHALL abort the load without a further write, and start is required again after reset.

Configuration
REQ-029 Macro RAMB_WRITER_TRANSPOSE_EN:
- When defined, element k SHALL be written to waddr=(k mod DIM)*DIM + (k div DIM), storing B column-major so that one read port fetches B columns contiguously.
- When undefined, waddr=k.
- All other behaviour is identical in both builds.

Verification
REQ-030 Reset, start, then 64 back-to-back elements with values -32..31 -> we on 64 consecutive cycles, waddr 0..63, wdata -32..31, done=1 in the cycle of the last write, count=64.
REQ-031 Load with in_valid toggling every other cycle -> exactly 64 writes, no duplicate or skipped address, and we never high in the cycle after a stall.
REQ-032 start pulsed at element 20 during LOAD -> ignored; count continues 21, 22, ...; the load completes normally.
REQ-033 rst_n low after element 30 -> all outputs 0 immediately; a new start rewrites from waddr 0.
REQ-034 With RAMB_WRITER_TRANSPOSE_EN defined, elements k=0, 1, 8, 63 -> waddr=0, 8, 1, 63 respectively.
REQ-035 From DONE, a second start with 64 elements of 0x7F -> count cleared to 0 and 64 writes of 127; done drops on the start edge and rises again on completion.
